// File: rtl/rot_reg_sequencer_pkg.sv
// Shared opcode and state encodings for the rotating/shifting register sequencer.
package rot_reg_sequencer_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_ROTATE = 2'b01;
    localparam logic [1:0] OP_SHIFT  = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    // Sequencer state encodings
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

endpackage

// File: rtl/rot_step_counter.sv
// Step counter: parallel load, decrement-enable, zero flag.
module rot_step_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Load takes priority over decrement; decrement never wraps below zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/rot_reg_sequencer.sv
// Command sequencer driving the rotating/shifting register datapath controls.
module rot_reg_sequencer
    import rot_reg_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             pause,
    input  logic             abort,
    output logic             loadn,
    output logic             rotate_right,
    output logic             ls_right,
    output logic             shift_en,
    output logic [WIDTH-1:0] load_data,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             aborted_q, aborted_d;

    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             step_fire;
    logic             last_step;

    assign accept    = cmd_valid && cmd_ready;
    assign step_fire = (state_q == S_STEP) && !pause && !abort;
    assign cnt_dec   = step_fire;
    assign last_step = (cnt == CNT_W'(1)) || cnt_zero;

    rot_step_counter #(
        .CNT_W(CNT_W)
    ) u_step_counter (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .count_o    (cnt),
        .zero_o     (cnt_zero)
    );

    // Next-state and command capture
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dir_d     = dir_q;
        data_d    = data_q;
        aborted_d = aborted_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d      = cmd_op;
                    dir_d     = cmd_dir;
                    aborted_d = 1'b0;
                    cnt_load  = 1'b1;
                    if ((cmd_op == OP_LOAD) || (cmd_op == OP_CLEAR)) begin
                        data_d  = (cmd_op == OP_CLEAR) ? '0 : cmd_data;
                        state_d = S_LOAD;
                    end else begin
                        cnt_val = cmd_steps;
                        state_d = (cmd_steps == '0) ? S_DONE : S_STEP;
                    end
                end
            end
            S_LOAD: state_d = S_DONE;
            S_STEP: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (!pause && last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured command registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_LOAD;
            dir_q     <= 1'b0;
            data_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dir_q     <= dir_d;
            data_q    <= data_d;
            aborted_q <= aborted_d;
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign aborted      = (state_q == S_DONE) && aborted_q;
    assign loadn        = (state_q != S_LOAD);
    assign shift_en     = (state_q == S_LOAD) || step_fire;
    assign rotate_right = (state_q == S_STEP) && dir_q;
    assign ls_right     = (state_q == S_STEP) && (op_q == OP_SHIFT);
    assign load_data    = data_q;
    assign steps_left   = cnt;

endmodule

// File: tb/tb_rot_reg_sequencer.sv
// Directed testbench for rot_reg_sequencer.
module tb_rot_reg_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_dir;
    logic [3:0] cmd_steps;
    logic [7:0] cmd_data;
    logic       pause;
    logic       abort;
    logic       loadn;
    logic       rotate_right;
    logic       ls_right;
    logic       shift_en;
    logic [7:0] load_data;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] steps_left;

    int checks;
    int failures;

    // {cmd_ready, busy, loadn, shift_en, rotate_right, ls_right, done, aborted, steps_left}
    logic [11:0] obs;
    logic [11:0] exp_v;
    assign obs = {cmd_ready, busy, loadn, shift_en, rotate_right, ls_right, done, aborted, steps_left};

    rot_reg_sequencer #(
        .WIDTH(8),
        .CNT_W(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_dir      (cmd_dir),
        .cmd_steps    (cmd_steps),
        .cmd_data     (cmd_data),
        .pause        (pause),
        .abort        (abort),
        .loadn        (loadn),
        .rotate_right (rotate_right),
        .ls_right     (ls_right),
        .shift_en     (shift_en),
        .load_data    (load_data),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .steps_left   (steps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        cmd_valid = 0; cmd_op = 0; cmd_dir = 0; cmd_steps = 0; cmd_data = 0;
        pause = 0; abort = 0;
        reset = 0;
        #2;
        exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs, exp_v);
        end
        checks++;
        if (load_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_load_data got=%h exp=00", load_data);
        end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
    endtask

    // LOAD A5 with abort held during LOAD (ignored), then CLEAR with pause held (ignored)
    task automatic test_load;
        cmd_op = 2'b00; cmd_data = 8'hA5; cmd_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            cmd_valid = 0;
            cmd_data  = 8'h3C;
            abort     = (i == 1);
            @(negedge clk);
            case (i)
                1: exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
                2: exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
                default: exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
            endcase
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL load_cycle%0d got=%h exp=%h", i, obs, exp_v);
            end
            checks++;
            if (load_data !== 8'hA5) begin
                failures++;
                $display("FAIL load_data_cycle%0d got=%h exp=a5", i, load_data);
            end
        end
        abort = 0;
        cmd_op = 2'b11; cmd_data = 8'hFF; cmd_valid = 1;
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk); #1;
            cmd_valid = 0;
            pause     = 1;
            @(negedge clk);
            if (i == 1) exp_v = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
            else        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL clear_cycle%0d got=%h exp=%h", i, obs, exp_v);
            end
            checks++;
            if (load_data !== 8'h00) begin
                failures++;
                $display("FAIL clear_data_cycle%0d got=%h exp=00", i, load_data);
            end
        end
        pause = 0;
        @(negedge clk);
    endtask

    // ROTATE right 3; dir flipped after acceptance must not matter
    task automatic test_rotate;
        cmd_op = 2'b01; cmd_dir = 1; cmd_steps = 4'd3; cmd_valid = 1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            cmd_valid = 0; cmd_dir = 0; cmd_steps = 4'd9;
            @(negedge clk);
            case (i)
                1: exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3};
                2: exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2};
                3: exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
                4: exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
                default: exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
            endcase
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL rotate_cycle%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
    endtask

    // SHIFT left 4 with pause in k+2
    task automatic test_shift_pause;
        cmd_op = 2'b10; cmd_dir = 0; cmd_steps = 4'd4; cmd_valid = 1;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            cmd_valid = 0;
            pause     = (i == 2);
            @(negedge clk);
            case (i)
                1: exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4};
                2: exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3};
                3: exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3};
                4: exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
                5: exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
                6: exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
                default: exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
            endcase
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL shift_pause_cycle%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
        pause = 0;
    endtask

    // ROTATE right 5, abort and pause together in k+3
    task automatic test_abort;
        cmd_op = 2'b01; cmd_dir = 1; cmd_steps = 4'd5; cmd_valid = 1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            cmd_valid = 0;
            abort     = (i == 3);
            pause     = (i == 3);
            @(negedge clk);
            case (i)
                1: exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5};
                2: exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4};
                3: exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3};
                4: exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3};
                default: exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
            endcase
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL abort_cycle%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
        abort = 0; pause = 0;
    endtask

    // steps=0 with cmd_valid held high: accepts only when cmd_ready is back
    task automatic test_back_to_back;
        cmd_op = 2'b10; cmd_dir = 1; cmd_steps = 4'd0; cmd_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (i == 3) cmd_valid = 0;
            @(negedge clk);
            case (i)
                1: exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
                2: exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
                3: exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
                default: exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
            endcase
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL back_to_back_cycle%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
    endtask

    // Async reset in the middle of a ROTATE
    task automatic test_reset_mid;
        cmd_op = 2'b01; cmd_dir = 1; cmd_steps = 4'd9; cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || steps_left !== 4'd8) begin
            failures++;
            $display("FAIL reset_mid_pre got busy=%b steps=%0d exp busy=1 steps=8", busy, steps_left);
        end
        #2 reset = 0;
        #1;
        exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=%h", obs, exp_v);
        end
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_mid_after got=%h exp=%h", obs, exp_v);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
        test_load;
        test_rotate;
        test_shift_pause;
        test_abort;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
